ram_lp_ctrl: RTL and testbench
==============================

RAM_LP_CTRL -- requirements
Module: ram_lp_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named CLK and RST_N.
REQ-002 Parameter AW, default 2: RAM address width.
REQ-003 Parameter DW, default 3: RAM data width.
REQ-004 Parameter IDLE_TH, default 8, legal range 2..255: consecutive idle cycles before sleep entry.
REQ-005 Port CLK  input  1  rising-edge clock.
REQ-006 Port RST_N  input  1  asynchronous active-low reset.
REQ-007 Port req_valid  input  1  request present.
REQ-008 Port req_ready  output  1  request accepted when high together with req_valid.
REQ-009 Port req_wr  input  1  1 = write, 0 = read.
REQ-010 Port req_addr  input  AW  request address.
REQ-011 Port req_wdata  input  DW  write data.
REQ-012 Port rsp_valid  output  1  read data valid.
REQ-013 Port rsp_ready  input  1  consumer takes rsp_rdata.
REQ-014 Port rsp_rdata  output  DW  read data, driven directly from ram_Q.
REQ-015 Port ram_A / ram_D / ram_EN / ram_WR  output  AW / DW / 1 / 1  to the downstream RAM A, D, EN, WR.
REQ-016 Port ram_Q  input  DW  RAM registered read data, which updates only on the edge after EN=1 and WR=0.
REQ-017 Port ram_sleep  output  1  RAM retention/sleep request.

Function
REQ-018 An accept SHALL be defined as req_valid & req_ready in the same cycle.
REQ-019 ram_EN SHALL equal accept combinationally, and ram_WR SHALL equal req_wr when accept is high and 0 otherwise.
REQ-020 ram_A and ram_D SHALL equal req_addr and req_wdata on accept, and SHALL otherwise hold the last accepted values so the bus does not toggle while idle.
REQ-021 The FSM SHALL have three states: ACTIVE, SLEEP and WAKE.
REQ-022 In ACTIVE, req_ready SHALL equal !rsp_valid | rsp_ready.
REQ-023 A read accepted at edge N SHALL set rsp_valid from edge N+1, giving a latency of 1 cycle.
REQ-024 rsp_valid SHALL clear on the edge where rsp_valid & rsp_ready, unless a read is accepted in the same cycle, in which case it stays 1 and rsp_rdata updates.
REQ-025 rsp_valid and rsp_rdata SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-026 A write SHALL produce no response and SHALL not affect rsp_valid or rsp_rdata.
REQ-027 A write accepted while a response is pending SHALL be legal.
REQ-028 An idle cycle SHALL be a cycle in ACTIVE with no accept and rsp_valid=0.
REQ-029 An 8-bit idle_cnt SHALL increment on each idle cycle and clear on any non-idle cycle.
REQ-030 ACTIVE SHALL go to SLEEP on the edge where the current cycle is idle and idle_cnt == IDLE_TH-1, so that SLEEP is entered after exactly IDLE_TH idle cycles.
REQ-031 The idle_cnt counter SHALL clear on SLEEP entry.
REQ-032 A request accepted in the threshold cycle SHALL prevent SLEEP entry.
REQ-033 In SLEEP, ram_sleep SHALL be 1, req_ready SHALL be 0 and ram_EN SHALL be 0.
REQ-034 SLEEP SHALL go to WAKE on the edge where req_valid=1.
REQ-035 In WAKE, ram_sleep SHALL be 0 and req_ready SHALL be 0.
REQ-036 WAKE SHALL go to ACTIVE unconditionally after 1 cycle.
REQ-037 A request held across SLEEP and WAKE SHALL be accepted in the first ACTIVE cycle, 2 cycles after req_valid rose.
REQ-038 SLEEP SHALL be unreachable while rsp_valid=1.
REQ-039 ram_sleep SHALL be registered and SHALL be high only in SLEEP.
REQ-040 No request SHALL be dropped or duplicated.
REQ-041 Back-to-back reads with rsp_ready held at 1 SHALL sustain 1 accept per cycle.

Reset
REQ-042 While RST_N=0, the FSM SHALL be in ACTIVE.
REQ-043 While RST_N=0, idle_cnt, rsp_valid, ram_sleep, ram_A, ram_D, ram_EN and ram_WR SHALL all be 0.
REQ-044 Reset SHALL take effect asynchronously on RST_N falling, and deassertion SHALL be used synchronously to CLK.
REQ-045 Reset asserted mid-operation, including in SLEEP, WAKE or with a pending response, SHALL discard all state with no spurious ram_EN pulse.

Verification
REQ-046 The bench SHALL cover: write addr 1 data 5, then read addr 1 with rsp_ready=1 -> ram_EN=1 on each accept cycle, rsp_valid=1 one cycle after the read accept, rsp_rdata=5, ram_WR=1 only on the write.
REQ-047 The bench SHALL cover: read addr 2 with rsp_ready=0 for 3 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; rsp_ready=1 -> rsp_valid clears next edge and req_ready returns to 1.
REQ-048 The bench SHALL cover: IDLE_TH=8, no requests after reset -> ram_sleep rises on the 8th edge and ram_A and ram_D unchanged throughout.
REQ-049 The bench SHALL cover: in SLEEP, req_valid=1 for a read of addr 3 -> WAKE next cycle with ram_sleep=0, accept in the following cycle, and rsp_valid 1 cycle later.
REQ-050 The bench SHALL cover: a request arriving on the 8th idle cycle -> accepted, no SLEEP entry, idle_cnt=0.
REQ-051 The bench SHALL cover: RST_N pulsed low while rsp_valid=1 -> rsp_valid=0 and FSM in ACTIVE immediately, with no ram_EN pulse at reset release.

Source files
------------

// File: rtl/ram_lp_ctrl.sv
// Request/response front-end for a single-port RAM with idle-driven sleep entry.
// The RAM read port is registered, so read data returns one cycle after accept.
module ram_lp_ctrl #(
    parameter int AW      = 2,
    parameter int DW      = 3,
    parameter int IDLE_TH = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] ram_A,
    output logic [DW-1:0] ram_D,
    output logic          ram_EN,
    output logic          ram_WR,
    input  logic [DW-1:0] ram_Q,
    output logic          ram_sleep
);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_SLEEP  = 2'd1;
    localparam logic [1:0] ST_WAKE   = 2'd2;

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_TH - 1);

    logic [1:0]    state_q, state_d;
    logic [7:0]    idle_cnt_q, idle_cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          ram_sleep_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          accept;
    logic          idle;

    // Gating with RST_N keeps ram_EN low for the whole reset window,
    // even though the flops already sit in their ACTIVE reset state.
    assign req_ready = RST_N && (state_q == ST_ACTIVE) && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign idle      = (state_q == ST_ACTIVE) && !accept && !rsp_valid_q;

    assign ram_EN    = accept;
    assign ram_WR    = accept && req_wr;
    assign ram_A     = accept ? req_addr  : addr_q;
    assign ram_D     = accept ? req_wdata : wdata_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = ram_Q;
    assign ram_sleep = ram_sleep_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d     = state_q;
        idle_cnt_d  = 8'd0;
        rsp_valid_d = rsp_valid_q;

        if (accept && !req_wr) begin
            rsp_valid_d = 1'b1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            ST_ACTIVE: begin
                if (idle) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d = ST_SLEEP;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 8'd1;
                    end
                end
            end
            ST_SLEEP: begin
                if (req_valid) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE:  state_d = ST_ACTIVE;
            default:  state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_ACTIVE;
            idle_cnt_q  <= 8'd0;
            rsp_valid_q <= 1'b0;
            ram_sleep_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            ram_sleep_q <= (state_d == ST_SLEEP);
            addr_q      <= ram_A;
            wdata_q     <= ram_D;
        end
    end

endmodule

// File: tb/tb_ram_lp_ctrl.sv
// Directed bench for ram_lp_ctrl: a behavioural RAM answers the controller,
// and read responses are checked against a queue filled when reads are driven.
module tb_ram_lp_ctrl;

    localparam int AW = 2;
    localparam int DW = 3;

    logic          CLK;
    logic          RST_N;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_A;
    logic [DW-1:0] ram_D;
    logic          ram_EN;
    logic          ram_WR;
    logic [DW-1:0] ram_Q;
    logic          ram_sleep;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] shadow[4];
    logic [DW-1:0] mem[4];

    ram_lp_ctrl #(.AW(AW), .DW(DW), .IDLE_TH(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_A     (ram_A),
        .ram_D     (ram_D),
        .ram_EN    (ram_EN),
        .ram_WR    (ram_WR),
        .ram_Q     (ram_Q),
        .ram_sleep (ram_sleep)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Downstream RAM: Q only moves on a read-enable edge.
    always @(posedge CLK) begin
        if (ram_EN) begin
            if (ram_WR) mem[ram_A] <= ram_D;
            else        ram_Q      <= mem[ram_A];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = v;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
    endtask

    // Response monitor: every completed handshake must match the oldest expected read.
    always @(negedge CLK) begin
        if (RST_N && rsp_valid && rsp_ready) begin
            check("rsp_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        shadow[0] = 3'd2; shadow[1] = 3'd1; shadow[2] = 3'd6; shadow[3] = 3'd4;
        for (int i = 0; i < 4; i++) mem[i] = shadow[i];
        ram_Q     = '0;
        RST_N     = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 2'd3, 3'd7);

        // Reset state, with a request already presented
        #2;
        check("rst_ram_EN", 32'(ram_EN), 32'd0);
        check("rst_ram_WR", 32'(ram_WR), 32'd0);
        check("rst_ram_A", 32'(ram_A), 32'd0);
        check("rst_ram_D", 32'(ram_D), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_ram_sleep", 32'(ram_sleep), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'd0);
        drive(1'b0, 1'b0, 2'd3, 3'd7);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Idle from reset: sleep on the 8th edge, RAM bus stays quiet
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("idle_ram_sleep", 32'(ram_sleep), 32'(e == 8));
            check("idle_ram_A", 32'(ram_A), 32'd0);
            check("idle_ram_D", 32'(ram_D), 32'd0);
        end
        check("sleep_state", 32'(dut.state_q), 32'd1);
        check("sleep_idle_cnt", 32'(dut.idle_cnt_q), 32'd0);

        // Wake-up read of addr 3
        drive(1'b1, 1'b0, 2'd3, 3'd0);
        #1;
        check("sleep_req_ready", 32'(req_ready), 32'd0);
        check("sleep_ram_EN", 32'(ram_EN), 32'd0);
        tick();
        check("wake_state", 32'(dut.state_q), 32'd2);
        check("wake_ram_sleep", 32'(ram_sleep), 32'd0);
        check("wake_req_ready", 32'(req_ready), 32'd0);
        tick();
        #1;
        check("wake_accept_EN", 32'(ram_EN), 32'd1);
        check("wake_accept_A", 32'(ram_A), 32'd3);
        exp_q.push_back(shadow[3]);
        tick();
        drive(1'b0, 1'b0, 2'd0, 3'd0);
        check("wake_rsp_valid", 32'(rsp_valid), 32'd1);

        // Write addr 1 = 5, then read it back with rsp_ready high
        tick();
        drive(1'b1, 1'b1, 2'd1, 3'd5);
        #1;
        check("wr_ram_EN", 32'(ram_EN), 32'd1);
        check("wr_ram_WR", 32'(ram_WR), 32'd1);
        check("wr_ram_A", 32'(ram_A), 32'd1);
        check("wr_ram_D", 32'(ram_D), 32'd5);
        shadow[1] = 3'd5;
        tick();
        check("wr_no_rsp", 32'(rsp_valid), 32'd0);
        drive(1'b1, 1'b0, 2'd1, 3'd0);
        #1;
        check("rd_ram_EN", 32'(ram_EN), 32'd1);
        check("rd_ram_WR", 32'(ram_WR), 32'd0);
        exp_q.push_back(shadow[1]);
        tick();
        drive(1'b0, 1'b0, 2'd0, 3'd0);
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_rdata", 32'(rsp_rdata), 32'd5);
        check("rd_hold_A", 32'(ram_A), 32'd1);
        tick();
        check("rd_rsp_clear", 32'(rsp_valid), 32'd0);

        // Back-pressured read of addr 2; a write waits behind it
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 2'd2, 3'd0);
        #1;
        check("bp_accept", 32'(req_ready), 32'd1);
        exp_q.push_back(shadow[2]);
        tick();
        drive(1'b1, 1'b1, 2'd0, 3'd3);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", 32'(rsp_rdata), 32'(shadow[2]));
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_ram_EN", 32'(ram_EN), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'd1);
        check("bp_release_WR", 32'(ram_WR), 32'd1);
        shadow[0] = 3'd3;
        tick();
        drive(1'b0, 1'b0, 2'd0, 3'd0);
        check("bp_rsp_clear", 32'(rsp_valid), 32'd0);

        // Back-to-back reads, one accept per cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'(i), 3'd0);
            #1;
            check("b2b_req_ready", 32'(req_ready), 32'd1);
            if (i > 0) check("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
            exp_q.push_back(shadow[i]);
            tick();
        end
        drive(1'b0, 1'b0, 2'd0, 3'd0);
        check("b2b_last_valid", 32'(rsp_valid), 32'd1);
        tick();
        check("b2b_clear", 32'(rsp_valid), 32'd0);

        // Request on the 8th idle cycle holds off sleep
        repeat (7) tick();
        check("th_idle_cnt", 32'(dut.idle_cnt_q), 32'd7);
        drive(1'b1, 1'b1, 2'd2, 3'd6);
        #1;
        check("th_req_ready", 32'(req_ready), 32'd1);
        shadow[2] = 3'd6;
        tick();
        drive(1'b0, 1'b0, 2'd0, 3'd0);
        check("th_ram_sleep", 32'(ram_sleep), 32'd0);
        check("th_state", 32'(dut.state_q), 32'd0);
        check("th_idle_cnt_clr", 32'(dut.idle_cnt_q), 32'd0);

        // Reset with a response pending
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 2'd2, 3'd0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 3'd0);
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        check("pre_rst_rdata", 32'(rsp_rdata), 32'(shadow[2]));
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_state", 32'(dut.state_q), 32'd0);
        check("mid_rst_EN", 32'(ram_EN), 32'd0);
        check("mid_rst_A", 32'(ram_A), 32'd0);
        rsp_ready = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("rel_ram_EN", 32'(ram_EN), 32'd0);
        tick();
        check("rel_ram_EN_edge", 32'(ram_EN), 32'd0);
        check("rel_rsp_valid", 32'(rsp_valid), 32'd0);

        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
